// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } arb_state_t;

  localparam int DATA_BITS_DEF = 8;

  // ceil(log2(n)), never less than 1 so single-entry indices still have a bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_rr_select.sv
// Circular first-set-bit search over Req starting at Ptr.
module uart_rr_select
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] Req,
  input  logic [ID_W-1:0]  Ptr,
  output logic             Valid,
  output logic [ID_W-1:0]  Idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] masked;
  logic               found;
  int unsigned        pos;

  // Lower copy masked below Ptr; upper copy supplies the wrap-around.
  always_comb begin
    dbl    = {Req, Req};
    masked = '0;
    for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
      masked[i] = dbl[i] && ((i >= N_REQ) || (i >= 32'(Ptr)));
    end
  end

  always_comb begin
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        pos   = i;
      end
    end
  end

  assign Valid = |Req;
  assign Idx   = ID_W'((pos >= N_REQ) ? (pos - N_REQ) : pos);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 64
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [N_REQ-1:0]               Req,
  input  logic [N_REQ*DATA_BITS-1:0]     Req_Data,
  input  logic                           Hold,
  output logic [N_REQ-1:0]               Ack,
  output logic [N_REQ-1:0]               Err,
  output logic [clog2_min1(N_REQ)-1:0]   Grant_Id,
  output logic [DATA_BITS-1:0]           Tx_Data,
  output logic                           Transmit_Start,
  input  logic                           Tx_Busy,
  output logic                           Arb_Busy
);

  localparam int ID_W = clog2_min1(N_REQ);
  localparam int TW   = clog2_min1(START_TIMEOUT);

  arb_state_t           state, state_nxt;
  logic [ID_W-1:0]      ptr, ptr_nxt;
  logic [TW-1:0]        timer, timer_nxt;
  logic [ID_W-1:0]      gid_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 ts_nxt;
  logic [N_REQ-1:0]     ack_nxt, err_nxt;
  logic                 sel_valid;
  logic [ID_W-1:0]      sel_idx;
  logic [ID_W-1:0]      ptr_after;

  uart_rr_select #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_sel (
    .Req   (Req),
    .Ptr   (ptr),
    .Valid (sel_valid),
    .Idx   (sel_idx)
  );

  assign ptr_after = (Grant_Id == ID_W'(N_REQ - 1)) ? '0 : Grant_Id + 1'b1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    timer_nxt = timer;
    gid_nxt   = Grant_Id;
    data_nxt  = Tx_Data;
    ts_nxt    = Transmit_Start;
    ack_nxt   = '0;
    err_nxt   = '0;
    case (state)
      IDLE: begin
        if (!Hold && !Tx_Busy && sel_valid) begin
          data_nxt  = Req_Data[sel_idx*DATA_BITS +: DATA_BITS];
          gid_nxt   = sel_idx;
          ts_nxt    = 1'b1;
          timer_nxt = '0;
          state_nxt = START;
        end
      end
      START: begin
        // Busy seen on the final timeout cycle still wins over the abort.
        if (Tx_Busy) begin
          ts_nxt            = 1'b0;
          ack_nxt[Grant_Id] = 1'b1;
          ptr_nxt           = ptr_after;
          state_nxt         = BUSY;
        end else if (timer == TW'(START_TIMEOUT - 1)) begin
          ts_nxt            = 1'b0;
          err_nxt[Grant_Id] = 1'b1;
          ptr_nxt           = ptr_after;
          state_nxt         = IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      BUSY: begin
        if (!Tx_Busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= IDLE;
      ptr            <= '0;
      timer          <= '0;
      Grant_Id       <= '0;
      Tx_Data        <= '0;
      Transmit_Start <= 1'b0;
      Ack            <= '0;
      Err            <= '0;
      Arb_Busy       <= 1'b0;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      timer          <= timer_nxt;
      Grant_Id       <= gid_nxt;
      Tx_Data        <= data_nxt;
      Transmit_Start <= ts_nxt;
      Ack            <= ack_nxt;
      Err            <= err_nxt;
      Arb_Busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed-vector bench for uart_tx_arbiter (N_REQ=4, DATA_BITS=8, START_TIMEOUT=64).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        hold;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [1:0]  grant_id;
  logic [7:0]  tx_data;
  logic        transmit_start;
  logic        tx_busy;
  logic        arb_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DATA_BITS     (8),
    .N_REQ         (4),
    .START_TIMEOUT (64)
  ) dut (
    .Clk            (clk),
    .Rst            (rst),
    .Req            (req),
    .Req_Data       (req_data),
    .Hold           (hold),
    .Ack            (ack),
    .Err            (err),
    .Grant_Id       (grant_id),
    .Tx_Data        (tx_data),
    .Transmit_Start (transmit_start),
    .Tx_Busy        (tx_busy),
    .Arb_Busy       (arb_busy)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({transmit_start, tx_data, ack, err, grant_id, arb_busy} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ts=%b data=%h ack=%b err=%b gid=%0d busy=%b, want all 0",
               transmit_start, tx_data, ack, err, grant_id, arb_busy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    req_data = 32'h0000_A500;
    req = 4'b0010;
    step();
    vectors++;
    if (transmit_start !== 1'b1 || tx_data !== 8'hA5 || grant_id !== 2'd1 || arb_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: got ts=%b data=%h gid=%0d busy=%b, want 1 a5 1 1",
               transmit_start, tx_data, grant_id, arb_busy);
    end
    step();
    step();
    vectors++;
    if (transmit_start !== 1'b1 || ack !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_hold_start: got ts=%b ack=%b, want 1 0000", transmit_start, ack);
    end
    tx_busy = 1'b1;
    step();
    vectors++;
    if (ack !== 4'b0010 || transmit_start !== 1'b0 || arb_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ack: got ack=%b ts=%b busy=%b, want 0010 0 1", ack, transmit_start, arb_busy);
    end
    req = 4'b0000;
    step();
    vectors++;
    if (ack !== 4'b0000 || arb_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ack_pulse: got ack=%b busy=%b, want 0000 1", ack, arb_busy);
    end
    tx_busy = 1'b0;
    step();
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: got busy=%b, want 0", arb_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [4];
    int         order [5];
    bit         seen;
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    order    = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        step();
        if (transmit_start === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
        miscompares++;
        $display("FAIL rr_start_%0d: got no Transmit_Start within 20 cycles, want grant", n);
      end
      vectors++;
      if (grant_id !== 2'(order[n]) || tx_data !== exp_data[order[n]]) begin
        miscompares++;
        $display("FAIL rr_grant_%0d: got gid=%0d data=%h, want gid=%0d data=%h",
                 n, grant_id, tx_data, order[n], exp_data[order[n]]);
      end
      tx_busy = 1'b1;
      step();
      vectors++;
      if (ack !== 4'(1 << order[n])) begin
        miscompares++;
        $display("FAIL rr_ack_%0d: got ack=%b, want %b", n, ack, 4'(1 << order[n]));
      end
      req[order[n]] = 1'b0;
      for (int c = 0; c < 11; c++) step();
      tx_busy = 1'b0;
      req[order[n]] = 1'b1;
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_timeout();
    int  ts_cycles = 0;
    int  err_pulses = 0;
    bit  ack_seen = 1'b0;
    logic [3:0] err_val = 4'b0000;
    req_data = 32'h00C3_0000;
    req = 4'b0100;
    for (int c = 0; c < 100; c++) begin
      step();
      if (transmit_start === 1'b1) ts_cycles++;
      if (ack !== 4'b0000) ack_seen = 1'b1;
      if (err !== 4'b0000) begin
        err_pulses++;
        err_val = err;
        req = 4'b0000;
      end
      if (c > 0 && transmit_start !== 1'b1) break;
    end
    step();
    if (err !== 4'b0000) err_pulses++;
    vectors++;
    if (ts_cycles != 64) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d cycles of Transmit_Start, want 64", ts_cycles);
    end
    vectors++;
    if (err_pulses != 1 || err_val !== 4'b0100 || ack_seen) begin
      miscompares++;
      $display("FAIL timeout_err: got pulses=%0d err=%b ack_seen=%b, want 1 0100 0",
               err_pulses, err_val, ack_seen);
    end
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_idle: got busy=%b, want 0", arb_busy);
    end
    req = 4'b1111;
    step();
    vectors++;
    if (grant_id !== 2'd3 || transmit_start !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_ptr: got gid=%0d ts=%b, want 3 1", grant_id, transmit_start);
    end
    tx_busy = 1'b1;
    step();
    req = 4'b0000;
    tx_busy = 1'b0;
    step();
    step();
  endtask

  task automatic test_hold_busy();
    bit started = 1'b0;
    req_data = 32'h0000_005A;
    req = 4'b0001;
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (transmit_start !== 1'b0) started = 1'b1;
    end
    hold = 1'b0;
    tx_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (transmit_start !== 1'b0) started = 1'b1;
    end
    vectors++;
    if (started) begin
      miscompares++;
      $display("FAIL hold_block: got Transmit_Start=1 while blocked, want 0");
    end
    tx_busy = 1'b0;
    step();
    vectors++;
    if (transmit_start !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL hold_release: got ts=%b gid=%0d data=%h, want 1 0 5a",
               transmit_start, grant_id, tx_data);
    end
    tx_busy = 1'b1;
    step();
    vectors++;
    if (ack !== 4'b0001) begin
      miscompares++;
      $display("FAIL hold_ack: got ack=%b, want 0001", ack);
    end
    req = 4'b0000;
    tx_busy = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid_start();
    bit pulse = 1'b0;
    req_data = 32'h7E00_3C00;
    req = 4'b0010;
    step();
    vectors++;
    if (transmit_start !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: got ts=%b, want 1", transmit_start);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({transmit_start, tx_data, ack, err, grant_id, arb_busy} !== 19'd0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got ts=%b data=%h ack=%b err=%b gid=%0d busy=%b, want all 0",
               transmit_start, tx_data, ack, err, grant_id, arb_busy);
    end
    rst = 1'b0;
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      if (ack !== 4'b0000 || err !== 4'b0000 || transmit_start !== 1'b0) pulse = 1'b1;
    end
    vectors++;
    if (pulse) begin
      miscompares++;
      $display("FAIL rstmid_quiet: got Ack/Err/Start activity after reset, want none");
    end
    req = 4'b1000;
    step();
    vectors++;
    if (transmit_start !== 1'b1 || grant_id !== 2'd3 || tx_data !== 8'h7E) begin
      miscompares++;
      $display("FAIL rstmid_regrant: got ts=%b gid=%0d data=%h, want 1 3 7e",
               transmit_start, grant_id, tx_data);
    end
    tx_busy = 1'b1;
    step();
    req = 4'b0000;
    tx_busy = 1'b0;
    step();
    step();
  endtask

  task automatic test_late_busy();
    bit dropped = 1'b0;
    req_data = 32'h0000_0096;
    req = 4'b0001;
    step();
    vectors++;
    if (transmit_start !== 1'b1 || grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL late_grant: got ts=%b gid=%0d, want 1 0", transmit_start, grant_id);
    end
    for (int c = 0; c < 63; c++) begin
      step();
      if (transmit_start !== 1'b1 || err !== 4'b0000) dropped = 1'b1;
    end
    vectors++;
    if (dropped) begin
      miscompares++;
      $display("FAIL late_hold: got Start dropped or Err before last cycle, want held");
    end
    tx_busy = 1'b1;
    step();
    vectors++;
    if (ack !== 4'b0001 || err !== 4'b0000 || transmit_start !== 1'b0 || arb_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL late_ack: got ack=%b err=%b ts=%b busy=%b, want 0001 0000 0 1",
               ack, err, transmit_start, arb_busy);
    end
    req = 4'b0000;
    step();
    vectors++;
    if (arb_busy !== 1'b1 || err !== 4'b0000) begin
      miscompares++;
      $display("FAIL late_busy_state: got busy=%b err=%b, want 1 0000", arb_busy, err);
    end
    tx_busy = 1'b0;
    step();
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    hold     = 1'b0;
    tx_busy  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_hold_busy();
    test_reset_mid_start();
    test_late_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (Tx_Data / Transmit_Start / Tx_Busy handshake) between N_REQ byte-level requesters, e.g. host port, BIST sequencer and status reporter.
- Round-robin fair grant; sequences the start handshake: hold Transmit_Start until Tx_Busy rises, then wait for Tx_Busy to fall.
- Sits between the requesters and the UART transmit inputs, clocked on the UART's Clk domain.

Parameters:
DATA_BITS, 8, width of one transmitted data word (must match UART DATA_BITS)
N_REQ, 4, number of requesters (1..16)
START_TIMEOUT, 64, max Clk cycles Transmit_Start is held waiting for Tx_Busy before aborting (>=2)

Ports:
Clk  input  1  single clock, all logic on posedge
Rst  input  1  synchronous reset, active-high
Req  input  N_REQ  per-requester request; held with Req_Data stable until Ack or Err
Req_Data  input  N_REQ*DATA_BITS  requester i's word at bits [i*DATA_BITS +: DATA_BITS]
Hold  input  1  when 1, no new grant issued (in-flight transfer completes)
Ack  output  N_REQ  one-cycle pulse: word accepted by transmitter
Err  output  N_REQ  one-cycle pulse: start timeout, word not sent
Grant_Id  output  clog2(N_REQ) (min 1)  index of current/last granted requester
Tx_Data  output  DATA_BITS  to UART Tx_Data
Transmit_Start  output  1  to UART Transmit_Start
Tx_Busy  input  1  from UART Tx_Busy
Arb_Busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (Rst=1 at posedge): state IDLE, Transmit_Start=0, Tx_Data=0, Ack=0, Err=0, Grant_Id=0, Arb_Busy=0, round-robin pointer Ptr=0, timer=0. Reset mid-transfer drops Transmit_Start next edge; no Ack/Err issued.
- All outputs registered.
- States: IDLE, START, BUSY.
- IDLE: if Hold=0, Tx_Busy=0 and |Req:
  - k = first i with Req[i]=1, scanning Ptr, Ptr+1, ... mod N_REQ.
  - Tx_Data <= Req_Data[k], Grant_Id <= k, Transmit_Start <= 1, timer <= 0, go START.
  - Latency: Req sampled at edge t -> Transmit_Start high after edge t.
  - Tx_Busy=1 in IDLE (external/BIST use) blocks grants.
- START: Transmit_Start held 1, Tx_Data stable.
  - Tx_Busy=1 sampled: Transmit_Start <= 0, Ack[k] <= 1 for one cycle, Ptr <= (k+1) mod N_REQ, go BUSY.
  - Else timer increments. When timer == START_TIMEOUT-1 and Tx_Busy=0: Transmit_Start <= 0, Err[k] pulse, Ptr <= (k+1) mod N_REQ, go IDLE.
  - Tx_Busy rising on the timeout cycle counts as success (Ack, not Err).
- BUSY: wait for Tx_Busy=0 sampled, then go IDLE. A new grant may occur on the following edge; minimum gap is one IDLE cycle.
- Request handling:
  - Data latched at grant; Req deasserted after grant does not abort.
  - Req deasserted before grant is simply not selected.
  - A requester must drop Req on the cycle after Ack/Err or it will be re-queued at its next round-robin turn.
- Ack and Err never both set; at most one bit of Ack|Err set per cycle.
- Hold rising in START/BUSY has no effect until return to IDLE.
- Fairness: with all Req held high, grants rotate 0,1,...,N_REQ-1,0.
- N_REQ=1: Ptr constant 0, Grant_Id 0.

Decomposition:
- uart_pkg: arb_state_t enum {IDLE, START, BUSY}; shared DATA_BITS default; function clog2_min1.
- Sub-module uart_rr_select: combinational; inputs Req, Ptr; outputs Valid and Idx (first set bit at/after Ptr, circular). Implemented via double-width masked priority encode.
- Top holds FSM, timer, Ptr and output registers.

Test Plan:
- Single request: Req=4'b0010, Req_Data[1]=8'hA5, Tx_Busy rises 3 cycles after Transmit_Start -> Transmit_Start high 1 cycle after Req sampled; Tx_Data=8'hA5; Grant_Id=1; Ack=4'b0010 one cycle after Tx_Busy seen; Transmit_Start low same edge.
- Simultaneous requests: Req=4'b1111 held, each re-raised after its Ack, UART model busy 12 cycles -> grant order 0,1,2,3,0; no requester granted twice before all others are served.
- Start timeout: START_TIMEOUT=64, Tx_Busy never rises, Req=4'b0100 -> Transmit_Start high exactly 64 cycles; Err=4'b0100 one pulse; Ack never set; Ptr advances to 3.
- Hold and external busy: Hold=1 or Tx_Busy=1 while in IDLE with Req=4'b0001 -> no Transmit_Start. Release -> grant on the next edge.
- Reset mid-START: assert Rst while Transmit_Start=1 -> next edge all outputs 0, state IDLE, no Ack/Err pulse. Subsequent Req=4'b1000 is granted normally, with Ptr restarting at 0.
- Late Tx_Busy: Tx_Busy rises on cycle START_TIMEOUT-1 -> Ack pulse, no Err, state BUSY.
